clk_div_core: RTL and testbench

CLK_DIV_CORE -- requirements
Module: clk_div_core

---
 rtl/clk_div_core_if.sv | 25 ++
 rtl/clk_div_core.sv | 133 +++++++++++++
 tb/tb_clk_div_core.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_core_if.sv
// Configuration and status bundle for clk_div_core.
// Master drives the cfg_* requests; slave is the divider core.
interface clk_div_core_if #(
    parameter int unsigned DIV_WIDTH = 32
);
    logic                 cfg_enable;
    logic [DIV_WIDTH-1:0] cfg_divisor;
    logic [DIV_WIDTH-1:0] cfg_high;
    logic                 cfg_update;
    logic                 clk_out;
    logic                 clk_en_pulse;
    logic [31:0]          period_cnt;
    logic                 cfg_busy;
    logic                 cfg_err;

    modport master (
        output cfg_enable, cfg_divisor, cfg_high, cfg_update,
        input  clk_out, clk_en_pulse, period_cnt, cfg_busy, cfg_err
    );

    modport slave (
        input  cfg_enable, cfg_divisor, cfg_high, cfg_update,
        output clk_out, clk_en_pulse, period_cnt, cfg_busy, cfg_err
    );
endinterface

// File: rtl/clk_div_core.sv
// Programmable clock divider; new configs are applied only at a period wrap.
// Define CLK_DIV_PERIOD_COUNT_EN to build the completed-period counter.
module clk_div_core #(
    parameter int unsigned DIV_WIDTH  = 32,
    parameter int unsigned RESET_DIV  = 4,
    parameter int unsigned RESET_HIGH = 2
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    clk_div_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(RESET_DIV);
    localparam logic [DIV_WIDTH-1:0] HIGH_RST = DIV_WIDTH'(RESET_HIGH);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] high_q, high_d;
    logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
    logic [DIV_WIDTH-1:0] phigh_q, phigh_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 clk_q, clk_d;
    logic                 en_q, en_d;
    logic                 legal, wrap, run_d;

    assign legal = (bus.cfg_divisor >= DIV_WIDTH'(2))
                && (bus.cfg_high != '0)
                && (bus.cfg_high < bus.cfg_divisor);
    assign wrap  = (state_q != IDLE) && (cnt_q == div_q - DIV_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        busy_d  = busy_q;
        err_d   = bus.cfg_update && !legal;

        // Pending config takes over at a wrap, or at once if we sit idle.
        if ((wrap || state_q == IDLE) && busy_q) begin
            div_d  = pdiv_q;
            high_d = phigh_q;
            busy_d = 1'b0;
        end

        if (bus.cfg_update && legal) begin
            if (state_q == IDLE) begin
                div_d  = bus.cfg_divisor;
                high_d = bus.cfg_high;
                busy_d = 1'b0;
            end else begin
                pdiv_d  = bus.cfg_divisor;
                phigh_d = bus.cfg_high;
                busy_d  = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.cfg_enable) state_d = RUN;
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
                if (!bus.cfg_enable) state_d = wrap ? IDLE : STOPPING;
            end
            STOPPING: begin
                cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
                if (bus.cfg_enable) state_d = RUN;
                else if (wrap)      state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        run_d = (state_d != IDLE);
        clk_d = run_d && (cnt_d < high_d);
        en_d  = run_d && (cnt_d == '0);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            high_q  <= HIGH_RST;
            pdiv_q  <= '0;
            phigh_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            clk_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            clk_q   <= clk_d;
            en_q    <= en_d;
        end
    end

`ifdef CLK_DIV_PERIOD_COUNT_EN
    logic [31:0] pcnt_q, pcnt_d;

    assign pcnt_d = pcnt_q + {31'd0, wrap};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) pcnt_q <= '0;
        else          pcnt_q <= pcnt_d;
    end

    assign bus.period_cnt = pcnt_q;
`else
    assign bus.period_cnt = '0;
`endif

    assign bus.clk_out      = clk_q;
    assign bus.clk_en_pulse = en_q;
    assign bus.cfg_busy     = busy_q;
    assign bus.cfg_err      = err_q;
endmodule

// File: tb/tb_clk_div_core.sv
// Directed bench for clk_div_core: patterns, deferred updates, errors, reset.
module tb_clk_div_core;
    logic ACLK;
    logic ARESETN;
    int   n_chk;
    int   n_fail;
    int   ph;

    clk_div_core_if #(.DIV_WIDTH(32)) bus ();

    clk_div_core #(
        .DIV_WIDTH (32),
        .RESET_DIV (4),
        .RESET_HIGH(2)
    ) dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .bus    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step one cycle and check the waveform against the expected count.
    task automatic advance(input int div, input int high, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge ACLK);
            ph = (ph + 1) % div;
            chk("clk_out", 32'(bus.clk_out), 32'(ph < high));
            chk("clk_en", 32'(bus.clk_en_pulse), 32'(ph == 0));
        end
    endtask

    function automatic logic [31:0] pexp(input int n);
`ifdef CLK_DIV_PERIOD_COUNT_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_clk"}, 32'(bus.clk_out), 32'd0);
        chk({tag, "_en"}, 32'(bus.clk_en_pulse), 32'd0);
        chk({tag, "_pcnt"}, bus.period_cnt, 32'd0);
        chk({tag, "_busy"}, 32'(bus.cfg_busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.cfg_err), 32'd0);
    endtask

    int bad_div [3] = '{1, 8, 6};
    int bad_high[3] = '{1, 0, 6};

    initial begin
        n_chk = 0;
        n_fail = 0;
        ph = 0;
        ARESETN = 1'b0;
        bus.cfg_enable = 1'b0;
        bus.cfg_update = 1'b0;
        bus.cfg_divisor = '0;
        bus.cfg_high = '0;
        #3;
        chk_reset("rst");
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("idle_clk", 32'(bus.clk_out), 32'd0);

        // Default 4/2 pattern
        bus.cfg_enable = 1'b1;
        ph = 3;
        advance(4, 2, 12);
        advance(4, 2, 1);
        chk("pcnt_12", bus.period_cnt, pexp(3));

        // Stop at cnt=1: two more cycles then idle
        advance(4, 2, 1);
        bus.cfg_enable = 1'b0;
        advance(4, 2, 2);
        @(negedge ACLK);
        chk("stop_clk", 32'(bus.clk_out), 32'd0);
        chk("stop_en", 32'(bus.clk_en_pulse), 32'd0);
        chk("stop_pcnt", bus.period_cnt, pexp(4));
        @(negedge ACLK);
        chk("idle2_clk", 32'(bus.clk_out), 32'd0);

        // Drop then re-raise before the wrap: no gap
        bus.cfg_enable = 1'b1;
        ph = 3;
        advance(4, 2, 2);
        bus.cfg_enable = 1'b0;
        advance(4, 2, 1);
        bus.cfg_enable = 1'b1;
        advance(4, 2, 6);

        // Update in RUN at cnt=1 is deferred to the wrap
        advance(4, 2, 1);
        bus.cfg_divisor = 32'd8;
        bus.cfg_high = 32'd4;
        bus.cfg_update = 1'b1;
        advance(4, 2, 1);
        bus.cfg_update = 1'b0;
        chk("busy_a", 32'(bus.cfg_busy), 32'd1);
        advance(4, 2, 1);
        chk("busy_b", 32'(bus.cfg_busy), 32'd1);
        advance(4, 2, 1);
        chk("busy_clr", 32'(bus.cfg_busy), 32'd0);
        advance(8, 4, 9);

        // Illegal updates
        for (int i = 0; i < 3; i++) begin
            bus.cfg_divisor = 32'(bad_div[i]);
            bus.cfg_high = 32'(bad_high[i]);
            bus.cfg_update = 1'b1;
            advance(8, 4, 1);
            bus.cfg_update = 1'b0;
            chk("err_hi", 32'(bus.cfg_err), 32'd1);
            chk("err_busy", 32'(bus.cfg_busy), 32'd0);
            advance(8, 4, 1);
            chk("err_lo", 32'(bus.cfg_err), 32'd0);
        end

        // Two pending updates: last one wins
        bus.cfg_divisor = 32'd6;
        bus.cfg_high = 32'd3;
        bus.cfg_update = 1'b1;
        advance(8, 4, 1);
        bus.cfg_divisor = 32'd5;
        bus.cfg_high = 32'd2;
        advance(8, 4, 1);
        bus.cfg_update = 1'b0;
        chk("busy_ow", 32'(bus.cfg_busy), 32'd1);
        advance(8, 4, 6);
        ph = 4;
        advance(5, 2, 1);
        chk("busy_ow_clr", 32'(bus.cfg_busy), 32'd0);
        advance(5, 2, 4);

        // Update coincident with wrap applies one period later
        bus.cfg_divisor = 32'd4;
        bus.cfg_high = 32'd1;
        bus.cfg_update = 1'b1;
        advance(5, 2, 1);
        bus.cfg_update = 1'b0;
        chk("busy_wrap", 32'(bus.cfg_busy), 32'd1);
        advance(5, 2, 4);
        chk("busy_wrap2", 32'(bus.cfg_busy), 32'd1);
        ph = 3;
        advance(4, 1, 1);
        chk("busy_wrap_clr", 32'(bus.cfg_busy), 32'd0);
        advance(4, 1, 4);

        // Asynchronous reset mid-run, clk_out high
        #2;
        ARESETN = 1'b0;
        #1;
        chk_reset("arst");
        bus.cfg_enable = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("arst_idle", 32'(bus.clk_out), 32'd0);

        // Update in IDLE loads immediately, never busy
        bus.cfg_divisor = 32'd5;
        bus.cfg_high = 32'd1;
        bus.cfg_update = 1'b1;
        @(negedge ACLK);
        bus.cfg_update = 1'b0;
        chk("idle_upd_busy", 32'(bus.cfg_busy), 32'd0);
        bus.cfg_enable = 1'b1;
        ph = 4;
        advance(5, 1, 10);
        chk("idle_upd_busy2", 32'(bus.cfg_busy), 32'd0);
        chk("pcnt_end", bus.period_cnt, pexp(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
